// File: rtl/debounce_toggle_pulse_if.sv
// debounce_toggle_pulse_if: button-conditioning bus between raw input source and debouncer
// Signals:
//   btn_in    raw push-button, active high, asynchronous, may bounce
//   t_pulse   one-cycle toggle-enable per accepted press
//   btn_level debounced button level
//   press_cnt wrapping count of accepted presses
// Modports: master drives btn_in and observes outputs; slave is the debouncer.
interface debounce_toggle_pulse_if #(
  parameter int PCNT_W = 8
);
  logic              btn_in;
  logic              t_pulse;
  logic              btn_level;
  logic [PCNT_W-1:0] press_cnt;
  modport master (output btn_in, input t_pulse, btn_level, press_cnt);
  modport slave  (input btn_in, output t_pulse, btn_level, press_cnt);
endinterface

// File: rtl/debounce_toggle_pulse.sv
// debounce_toggle_pulse: synchronise and debounce a raw button into a single-cycle toggle pulse
// Ports:
//   clk     system clock, rising edge
//   reset_n asynchronous active-low reset
//   bus     slave side of debounce_toggle_pulse_if (btn_in in; t_pulse, btn_level, press_cnt out)
module debounce_toggle_pulse #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter int PCNT_W        = 8
) (
  input logic                     clk,
  input logic                     reset_n,
  debounce_toggle_pulse_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t            state_q, state_d;
  logic              s1_q, s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              level_q, level_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              done, press_acc, rel_acc, waiting_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      s1_q    <= bus.btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      pcnt_q  <= pcnt_d;
    end
  assign done = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       state_d = s2_q ? WAIT_PRESS : IDLE;
      WAIT_PRESS: state_d = !s2_q ? IDLE : done ? PRESSED : WAIT_PRESS;
      PRESSED:    state_d = s2_q ? PRESSED : WAIT_RELEASE;
      default:    state_d = s2_q ? PRESSED : done ? IDLE : WAIT_RELEASE;
    endcase
  end
  // Counter runs only while staying in a WAIT state; entering one starts at 1
  // because the entering sample already counts as the first stable one.
  always_comb begin
    press_acc = state_q == WAIT_PRESS && s2_q && done;
    rel_acc   = state_q == WAIT_RELEASE && !s2_q && done;
    waiting_d = state_d == WAIT_PRESS || state_d == WAIT_RELEASE;
    cnt_d     = !waiting_d ? '0 : state_d == state_q ? cnt_q + CNT_W'(1) : CNT_W'(1);
    pulse_d   = press_acc;
    level_d   = press_acc | (level_q & ~rel_acc);
    pcnt_d    = pcnt_q + PCNT_W'(press_acc);
  end
  assign bus.t_pulse   = pulse_q;
  assign bus.btn_level = level_q;
  assign bus.press_cnt = pcnt_q;
endmodule

// File: tb/tb_debounce_toggle_pulse.sv
// tb_debounce_toggle_pulse: directed self-checking bench for debounce_toggle_pulse
module tb_debounce_toggle_pulse;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int na = 0, nb = 0, dbl = 0;
  logic qa = 1'b0, prev_a = 1'b0;
  debounce_toggle_pulse_if #(.PCNT_W(8)) a ();
  debounce_toggle_pulse_if #(.PCNT_W(2)) b ();
  debounce_toggle_pulse #(.STABLE_CYCLES(4), .CNT_W(16), .PCNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a)
  );
  debounce_toggle_pulse #(.STABLE_CYCLES(4), .CNT_W(16), .PCNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );
  always #5 clk = ~clk;
  // pulse counters, back-to-back detector and a downstream toggle flop
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      na     <= 0;
      nb     <= 0;
      qa     <= 1'b0;
      prev_a <= 1'b0;
    end else begin
      if (a.t_pulse) na <= na + 1;
      if (b.t_pulse) nb <= nb + 1;
      if (a.t_pulse) qa <= ~qa;
      if (a.t_pulse && prev_a) dbl <= dbl + 1;
      prev_a <= a.t_pulse;
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic t, input logic l, input logic [7:0] p);
    chk({tag, ".t_pulse"}, 32'(a.t_pulse), 32'(t));
    chk({tag, ".btn_level"}, 32'(a.btn_level), 32'(l));
    chk({tag, ".press_cnt"}, 32'(a.press_cnt), 32'(p));
  endtask
  initial begin
    a.btn_in = 1'b0;
    b.btn_in = 1'b0;
    #1;
    chk_a("reset", 1'b0, 1'b0, 8'd0);
    chk("reset_b.press_cnt", 32'(b.press_cnt), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(2);
    // bounce on press: high 2, low 1, high 2, low
    a.btn_in = 1'b1; step(2);
    a.btn_in = 1'b0; step(1);
    a.btn_in = 1'b1; step(2);
    a.btn_in = 1'b0; step(10);
    chk_a("bounce", 1'b0, 1'b0, 8'd0);
    chk("bounce.pulses", 32'(na), 32'd0);
    // clean press: e0 is the next edge
    a.btn_in = 1'b1;
    step(5);
    chk_a("press_e4", 1'b0, 1'b0, 8'd0);
    step(1);
    chk_a("press_e5", 1'b1, 1'b1, 8'd1);
    step(1);
    chk_a("press_e6", 1'b0, 1'b1, 8'd1);
    step(20);
    chk_a("held", 1'b0, 1'b1, 8'd1);
    chk("held.pulses", 32'(na), 32'd1);
    // release bounce: low 2, high, then low held
    a.btn_in = 1'b0; step(2);
    a.btn_in = 1'b1; step(6);
    chk_a("rel_bounce", 1'b0, 1'b1, 8'd1);
    a.btn_in = 1'b0;
    step(5);
    chk_a("release_e4", 1'b0, 1'b1, 8'd1);
    step(1);
    chk_a("release_e5", 1'b0, 1'b0, 8'd1);
    chk("release.pulses", 32'(na), 32'd1);
    // three clean presses from a fresh reset drive a toggle flop to 1
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    for (int i = 1; i <= 3; i++) begin
      a.btn_in = 1'b1; step(10);
      a.btn_in = 1'b0; step(10);
      chk("repeat.press_cnt", 32'(a.press_cnt), 32'(i));
    end
    chk("repeat.pulses", 32'(na), 32'd3);
    chk("repeat.toggle_q", 32'(qa), 32'd1);
    chk("repeat.level", 32'(a.btn_level), 32'd0);
    // reset mid-debounce: WAIT_PRESS with cnt=2 is reached after e3
    a.btn_in = 1'b1;
    step(4);
    chk_a("mid_before", 1'b0, 1'b0, 8'd3);
    reset_n = 1'b0;
    #1;
    chk_a("mid_reset", 1'b0, 1'b0, 8'd0);
    step(2);
    reset_n = 1'b1;
    step(5);
    chk_a("mid_e4", 1'b0, 1'b0, 8'd0);
    step(1);
    chk_a("mid_e5", 1'b1, 1'b1, 8'd1);
    step(1);
    chk_a("mid_e6", 1'b0, 1'b1, 8'd1);
    step(10);
    chk("mid.pulses", 32'(na), 32'd1);
    a.btn_in = 1'b0;
    step(10);
    // press counter wrap with a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      b.btn_in = 1'b1; step(10);
      b.btn_in = 1'b0; step(10);
      chk("wrap.press_cnt", 32'(b.press_cnt), 32'(i % 4));
    end
    chk("wrap.pulses", 32'(nb), 32'd5);
    chk("no_back_to_back", 32'(dbl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
